// File: rtl/global_defs.sv
// Shared types and default widths for the streaming top-K nearest-neighbour buffer.
package global_defs;

    localparam int KNN_K          = 8;
    localparam int KNN_DIST_WIDTH = 32;
    localparam int KNN_IDX_WIDTH  = 16;

    typedef struct packed {
        logic                      valid;
        logic [KNN_DIST_WIDTH-1:0] distance;
        logic [KNN_IDX_WIDTH-1:0]  index;
    } knn_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } topk_state_t;

endpackage

// File: rtl/topk_slot.sv
// One slot of the sorted buffer: compares a newcomer against its own entry and
// either holds, loads the newcomer, or takes the entry shifted down from above.
module topk_slot
    import global_defs::*;
#(
    parameter int DIST_WIDTH = KNN_DIST_WIDTH,
    parameter int IDX_WIDTH  = KNN_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  ins_en,
    input  logic [DIST_WIDTH-1:0] new_distance,
    input  logic [IDX_WIDTH-1:0]  new_index,
    input  logic                  prev_takes,
    input  logic                  prev_valid,
    input  logic [DIST_WIDTH-1:0] prev_distance,
    input  logic [IDX_WIDTH-1:0]  prev_index,
    output logic                  slot_valid,
    output logic [DIST_WIDTH-1:0] slot_distance,
    output logic [IDX_WIDTH-1:0]  slot_index,
    output logic                  takes
);

    logic                  valid_q, valid_d;
    logic [DIST_WIDTH-1:0] distance_q, distance_d;
    logic [IDX_WIDTH-1:0]  index_q, index_d;

    // Strictly greater keeps equal distances in arrival order.
    assign takes = !valid_q || (distance_q > new_distance);

    always_comb begin
        valid_d    = valid_q;
        distance_d = distance_q;
        index_d    = index_q;
        if (clear) begin
            valid_d    = 1'b0;
            distance_d = '1;
            index_d    = '0;
        end else if (ins_en && prev_takes) begin
            valid_d    = prev_valid;
            distance_d = prev_distance;
            index_d    = prev_index;
        end else if (ins_en && takes) begin
            valid_d    = 1'b1;
            distance_d = new_distance;
            index_d    = new_index;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            distance_q <= '1;
            index_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            distance_q <= distance_d;
            index_q    <= index_d;
        end
    end

    assign slot_valid    = valid_q;
    assign slot_distance = distance_q;
    assign slot_index    = index_q;

endmodule

// File: rtl/topk_stream.sv
// Streaming top-K selector: keeps the K smallest-distance candidates of a query
// in a sorted slot chain and drains them nearest-first after query_end.
module topk_stream
    import global_defs::*;
#(
    parameter int K          = KNN_K,
    parameter int DIST_WIDTH = KNN_DIST_WIDTH,
    parameter int IDX_WIDTH  = KNN_IDX_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   query_start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIST_WIDTH-1:0]  in_distance,
    input  logic [IDX_WIDTH-1:0]   in_index,
    input  logic                   query_end,
    input  logic [DIST_WIDTH-1:0]  running_mean,
    output logic [DIST_WIDTH-1:0]  threshold,
    output logic [$clog2(K+1)-1:0] count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIST_WIDTH-1:0]  out_distance,
    output logic [IDX_WIDTH-1:0]   out_index,
    output logic [$clog2(K)-1:0]   out_rank,
    output logic                   out_last,
    output logic                   busy
);

    localparam int CW = $clog2(K+1);
    localparam int RW = $clog2(K);

    topk_state_t state_q, state_d;

    logic [CW-1:0]         count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [RW-1:0]         out_rank_q, out_rank_d;
    logic [DIST_WIDTH-1:0] out_distance_q, out_distance_d;
    logic [IDX_WIDTH-1:0]  out_index_q, out_index_d;
    logic [RW-1:0]         next_rank;
    logic                  clear;
    logic                  accept;

    logic [K-1:0]          slot_valid, slot_takes, prev_takes, prev_valid;
    logic [DIST_WIDTH-1:0] slot_distance [K];
    logic [DIST_WIDTH-1:0] prev_distance [K];
    logic [IDX_WIDTH-1:0]  slot_index [K];
    logic [IDX_WIDTH-1:0]  prev_index [K];

    for (genvar i = 0; i < K; i++) begin : g_slot
        if (i == 0) begin : g_prev
            assign prev_takes[i]    = 1'b0;
            assign prev_valid[i]    = 1'b0;
            assign prev_distance[i] = '0;
            assign prev_index[i]    = '0;
        end else begin : g_prev
            assign prev_takes[i]    = slot_takes[i-1];
            assign prev_valid[i]    = slot_valid[i-1];
            assign prev_distance[i] = slot_distance[i-1];
            assign prev_index[i]    = slot_index[i-1];
        end

        topk_slot #(
            .DIST_WIDTH (DIST_WIDTH),
            .IDX_WIDTH  (IDX_WIDTH)
        ) u_slot (
            .clk           (clk),
            .rst           (reset),
            .clear         (clear),
            .ins_en        (accept),
            .new_distance  (in_distance),
            .new_index     (in_index),
            .prev_takes    (prev_takes[i]),
            .prev_valid    (prev_valid[i]),
            .prev_distance (prev_distance[i]),
            .prev_index    (prev_index[i]),
            .slot_valid    (slot_valid[i]),
            .slot_distance (slot_distance[i]),
            .slot_index    (slot_index[i]),
            .takes         (slot_takes[i])
        );
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        out_rank_d     = out_rank_q;
        out_distance_d = out_distance_q;
        out_index_d    = out_index_q;
        next_rank      = out_rank_q + RW'(1);
        clear          = 1'b0;
        accept         = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_COLLECT: begin
                accept = in_valid;
                if (query_end) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // out_valid stays high for the whole drain, so low here means first cycle.
                if (!out_valid_q) begin
                    if (count_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        out_valid_d    = 1'b1;
                        out_rank_d     = '0;
                        out_distance_d = slot_distance[0];
                        out_index_d    = slot_index[0];
                        out_last_d     = (count_q == CW'(1));
                    end
                end else if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        out_rank_d     = next_rank;
                        out_distance_d = slot_distance[next_rank];
                        out_index_d    = slot_index[next_rank];
                        out_last_d     = ((CW'(next_rank) + CW'(1)) == count_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (query_start) begin
            clear       = 1'b1;
            accept      = 1'b0;
            state_d     = ST_COLLECT;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_rank_d  = '0;
        end

        // Last slot takes the newcomer only when it is actually kept.
        if (clear) begin
            count_d = '0;
        end else if (accept && slot_takes[K-1] && (count_q != CW'(K))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_rank_q     <= '0;
            out_distance_q <= '0;
            out_index_q    <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_rank_q     <= out_rank_d;
            out_distance_q <= out_distance_d;
            out_index_q    <= out_index_d;
        end
    end

    assign in_ready     = (state_q == ST_COLLECT);
    assign busy         = (state_q != ST_IDLE);
    assign threshold    = slot_valid[K-1] ? slot_distance[K-1] : running_mean;
    assign count        = count_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_rank     = out_rank_q;
    assign out_distance = out_distance_q;
    assign out_index    = out_index_q;

endmodule

// File: tb/tb_topk_stream.sv
// Bench for topk_stream (K=4): directed scenarios plus randomized queries
// checked against a sorted-queue reference of the K nearest candidates.
module tb_topk_stream;
    import global_defs::*;

    localparam int K  = 4;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int CW = $clog2(K+1);
    localparam int RW = $clog2(K);

    logic          clk;
    logic          rst;
    logic          query_start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_distance;
    logic [IW-1:0] in_index;
    logic          query_end;
    logic [DW-1:0] running_mean;
    logic [DW-1:0] threshold;
    logic [CW-1:0] count;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_distance;
    logic [IW-1:0] out_index;
    logic [RW-1:0] out_rank;
    logic          out_last;
    logic          busy;

    topk_stream #(.K(K), .DIST_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk          (clk),
        .reset        (rst),
        .query_start  (query_start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_distance  (in_distance),
        .in_index     (in_index),
        .query_end    (query_end),
        .running_mean (running_mean),
        .threshold    (threshold),
        .count        (count),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_distance (out_distance),
        .out_index    (out_index),
        .out_rank     (out_rank),
        .out_last     (out_last),
        .busy         (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    // Reference: the K nearest so far, ascending, ties in arrival order.
    knn_entry_t          m_q[$];
    logic [DW+IW-1:0]    exp_q[$];
    logic [DW-1:0]       got_dist[$];
    logic [IW-1:0]       got_idx[$];
    logic [RW-1:0]       got_rank[$];
    logic                got_last[$];
    logic [DW+IW+RW-1:0] obs_val[$];
    logic                obs_rdy[$];

    function automatic void model_insert(input logic [DW-1:0] d, input logic [IW-1:0] idx);
        knn_entry_t e;
        int pos;
        e.valid = 1'b1;
        e.distance = d;
        e.index = idx;
        pos = m_q.size();
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].distance > d) pos = i;
        end
        m_q.insert(pos, e);
        if (m_q.size() > K) void'(m_q.pop_back());
    endfunction

    function automatic logic [DW-1:0] model_thr();
        return (m_q.size() == K) ? m_q[K-1].distance : running_mean;
    endfunction

    function automatic void load_exp();
        exp_q.delete();
        foreach (m_q[i]) exp_q.push_back({m_q[i].distance, m_q[i].index});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        query_start = 1'b0;
        in_valid = 1'b0;
        in_distance = '0;
        in_index = '0;
        query_end = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_query();
        query_start = 1'b1;
        tick();
        query_start = 1'b0;
        m_q.delete();
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] idx, input bit with_end);
        in_valid = 1'b1;
        in_distance = d;
        in_index = idx;
        query_end = with_end;
        tick();
        in_valid = 1'b0;
        query_end = 1'b0;
        model_insert(d, idx);
    endtask

    task automatic end_query();
        query_end = 1'b1;
        tick();
        query_end = 1'b0;
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1 over valid cycles; 2: random.
    task automatic drain(input int mode, output bit done);
        int vcnt;
        vcnt = 0;
        done = 1'b0;
        got_dist.delete(); got_idx.delete(); got_rank.delete(); got_last.delete();
        obs_val.delete(); obs_rdy.delete();
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = ((vcnt % 4) == 0) || ((vcnt % 4) == 3);
            else out_ready = 1'($urandom_range(0, 1));
            if (out_valid) begin
                vcnt++;
                obs_val.push_back({out_distance, out_index, out_rank});
                obs_rdy.push_back(out_ready);
            end
            if (out_valid && out_ready) begin
                got_dist.push_back(out_distance);
                got_idx.push_back(out_index);
                got_rank.push_back(out_rank);
                got_last.push_back(out_last);
                if (out_last) done = 1'b1;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        running_mean = 32'h1234_5678;
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        checks++; if (out_rank !== '0) begin errors++; $display("FAIL reset_out_rank: got %0d want 0", out_rank); end
        checks++; if (out_distance !== '0) begin errors++; $display("FAIL reset_out_distance: got %h want 0", out_distance); end
        checks++; if (out_index !== '0) begin errors++; $display("FAIL reset_out_index: got %h want 0", out_index); end
        checks++; if (threshold !== 32'h1234_5678) begin errors++; $display("FAIL reset_threshold: got %h want 12345678", threshold); end
        in_valid = 1'b1;
        in_distance = 32'd3;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== '0) begin errors++; $display("FAIL idle_no_accept: count got %0d want 0", count); end
    endtask

    task automatic test_directed_order();
        bit done;
        running_mean = 32'd1000;
        start_query();
        send(32'd50, 16'd1, 1'b0);
        send(32'd20, 16'd2, 1'b0);
        send(32'd70, 16'd3, 1'b0);
        send(32'd20, 16'd9, 1'b0);
        send(32'd10, 16'd5, 1'b0);
        end_query();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL dir_drain_entry: valid=%b busy=%b want 0/1", out_valid, busy); end
        drain(0, done);
        exp_q = '{{32'd10, 16'd5}, {32'd20, 16'd2}, {32'd20, 16'd9}, {32'd50, 16'd1}};
        checks++; if (!done || got_dist.size() != exp_q.size()) begin errors++; $display("FAIL dir_count: got %0d results want %0d", got_dist.size(), exp_q.size()); end
        for (int i = 0; i < got_dist.size() && i < exp_q.size(); i++) begin
            checks++; if ({got_dist[i], got_idx[i]} !== exp_q[i]) begin errors++; $display("FAIL dir_result%0d: got %h want %h", i, {got_dist[i], got_idx[i]}, exp_q[i]); end
            checks++; if (got_rank[i] !== RW'(i)) begin errors++; $display("FAIL dir_rank%0d: got %0d want %0d", i, got_rank[i], i); end
            checks++; if (got_last[i] !== (i == exp_q.size() - 1)) begin errors++; $display("FAIL dir_last%0d: got %b", i, got_last[i]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_threshold();
        int d_list [6]   = '{40, 30, 20, 60, 60, 5};
        int thr_list [6] = '{100, 100, 100, 60, 60, 40};
        int cnt_list [6] = '{1, 2, 3, 4, 4, 4};
        bit done;
        running_mean = 32'd100;
        start_query();
        checks++; if (threshold !== 32'd100) begin errors++; $display("FAIL thr_empty: got %0d want 100", threshold); end
        for (int i = 0; i < 6; i++) begin
            send(DW'(d_list[i]), IW'(i + 1), 1'b0);
            checks++; if (threshold !== DW'(thr_list[i])) begin errors++; $display("FAIL thr_step%0d: got %0d want %0d", i, threshold, thr_list[i]); end
            checks++; if (count !== CW'(cnt_list[i])) begin errors++; $display("FAIL thr_count%0d: got %0d want %0d", i, count, cnt_list[i]); end
        end
        end_query();
        drain(0, done);
        exp_q = '{{32'd5, 16'd6}, {32'd20, 16'd3}, {32'd30, 16'd2}, {32'd40, 16'd1}};
        checks++; if (!done || got_dist.size() != exp_q.size()) begin errors++; $display("FAIL thr_drain_count: got %0d want %0d", got_dist.size(), exp_q.size()); end
        for (int i = 0; i < got_dist.size() && i < exp_q.size(); i++) begin
            checks++; if ({got_dist[i], got_idx[i]} !== exp_q[i]) begin errors++; $display("FAIL thr_result%0d: got %h want %h", i, {got_dist[i], got_idx[i]}, exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        bit done;
        running_mean = 32'd500;
        start_query();
        for (int i = 0; i < 4; i++) send(DW'($urandom_range(0, 31)), IW'($urandom), 1'b0);
        load_exp();
        end_query();
        drain(1, done);
        checks++; if (!done || got_dist.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", got_dist.size(), exp_q.size()); end
        for (int i = 0; i < got_dist.size() && i < exp_q.size(); i++) begin
            checks++; if ({got_dist[i], got_idx[i]} !== exp_q[i]) begin errors++; $display("FAIL stall_result%0d: got %h want %h", i, {got_dist[i], got_idx[i]}, exp_q[i]); end
            checks++; if (got_rank[i] !== RW'(i)) begin errors++; $display("FAIL stall_rank%0d: got %0d want %0d", i, got_rank[i], i); end
            checks++; if (got_last[i] !== (i == exp_q.size() - 1)) begin errors++; $display("FAIL stall_last%0d: got %b", i, got_last[i]); end
        end
        for (int j = 1; j < obs_val.size(); j++) begin
            if (!obs_rdy[j-1]) begin
                checks++; if (obs_val[j] !== obs_val[j-1]) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", j, obs_val[j], obs_val[j-1]); end
            end
        end
    endtask

    task automatic test_empty_drain();
        start_query();
        end_query();
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL empty_entry: busy=%b valid=%b want 1/0", busy, out_valid); end
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL empty_exit: busy=%b valid=%b want 0/0", busy, out_valid); end
    endtask

    task automatic test_restart_in_drain();
        bit done;
        running_mean = 32'd77;
        start_query();
        for (int i = 0; i < 4; i++) send(DW'($urandom_range(0, 1000)), IW'(i), 1'b0);
        end_query();
        tick();
        checks++; if (out_valid !== 1'b1 || out_rank !== '0) begin errors++; $display("FAIL restart_rank0: valid=%b rank=%0d want 1/0", out_valid, out_rank); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_rank !== RW'(1)) begin errors++; $display("FAIL restart_rank1: got %0d want 1", out_rank); end
        tick();
        query_start = 1'b1;
        out_ready = 1'b0;
        tick();
        query_start = 1'b0;
        m_q.delete();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_valid: got %b want 0", out_valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL restart_count: got %0d want 0", count); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL restart_collect: in_ready=%b busy=%b want 1/1", in_ready, busy); end
        send(32'd7, 16'd3, 1'b0);
        end_query();
        drain(0, done);
        checks++; if (!done || got_dist.size() != 1) begin errors++; $display("FAIL restart_single: got %0d results want 1", got_dist.size()); end
        else begin
            checks++; if ({got_dist[0], got_idx[0], got_rank[0], got_last[0]} !== {32'd7, 16'd3, RW'(0), 1'b1})
                begin errors++; $display("FAIL restart_single_val: got %0d/%0d/%0d/%b want 7/3/0/1", got_dist[0], got_idx[0], got_rank[0], got_last[0]); end
        end
    endtask

    task automatic test_random();
        bit done;
        int n;
        bit combine;
        logic [DW-1:0] d;
        for (int q = 0; q < 14; q++) begin
            running_mean = DW'($urandom);
            start_query();
            n = $urandom_range(0, 9);
            combine = (n > 0) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                case ($urandom_range(0, 3))
                    0: d = DW'($urandom_range(0, 7));
                    1: d = (DW'($urandom_range(0, 7)) << 29) | DW'($urandom_range(0, 3));
                    2: d = DW'($urandom);
                    default: d = '1;
                endcase
                send(d, IW'($urandom), combine && (i == n - 1));
                checks++; if (count !== CW'(m_q.size())) begin errors++; $display("FAIL rnd_count q%0d i%0d: got %0d want %0d", q, i, count, m_q.size()); end
                checks++; if (threshold !== model_thr()) begin errors++; $display("FAIL rnd_thr q%0d i%0d: got %h want %h", q, i, threshold, model_thr()); end
            end
            if (!combine) end_query();
            load_exp();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_first_drain q%0d: valid got %b want 0", q, out_valid); end
            in_valid = 1'b1;
            in_distance = '0;
            in_index = 16'hdead;
            if (exp_q.size() == 0) begin
                tick();
                checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rnd_empty q%0d: busy=%b valid=%b want 0/0", q, busy, out_valid); end
            end else begin
                drain(2, done);
                checks++; if (!done || got_dist.size() != exp_q.size()) begin errors++; $display("FAIL rnd_drain_count q%0d: got %0d want %0d", q, got_dist.size(), exp_q.size()); end
                for (int i = 0; i < got_dist.size() && i < exp_q.size(); i++) begin
                    checks++; if ({got_dist[i], got_idx[i]} !== exp_q[i]) begin errors++; $display("FAIL rnd_result q%0d r%0d: got %h want %h", q, i, {got_dist[i], got_idx[i]}, exp_q[i]); end
                    checks++; if (got_rank[i] !== RW'(i)) begin errors++; $display("FAIL rnd_rank q%0d r%0d: got %0d want %0d", q, i, got_rank[i], i); end
                    checks++; if (got_last[i] !== (i == exp_q.size() - 1)) begin errors++; $display("FAIL rnd_last q%0d r%0d: got %b", q, i, got_last[i]); end
                end
            end
            checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_idle q%0d: in_ready=%b busy=%b want 0/0", q, in_ready, busy); end
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_collect();
        running_mean = 32'hcafe_0001;
        start_query();
        for (int i = 0; i < 3; i++) send(DW'($urandom_range(0, 99)), IW'(i), 1'b0);
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL rstmid_pre_count: got %0d want 3", count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== '0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", count); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state: busy=%b in_ready=%b want 0/0", busy, in_ready); end
        checks++; if (threshold !== 32'hcafe_0001) begin errors++; $display("FAIL rstmid_thr: got %h want cafe0001", threshold); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: busy=%b valid=%b want 0/0", busy, out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        query_start = 1'b0;
        in_valid = 1'b0;
        in_distance = '0;
        in_index = '0;
        query_end = 1'b0;
        out_ready = 1'b0;
        running_mean = '0;
        test_reset();
        test_directed_order();
        test_threshold();
        test_stall();
        test_empty_drain();
        test_restart_in_drain();
        test_random();
        test_reset_mid_collect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/topk_stream.md
TOPK_STREAM -- requirements
Module: topk_stream

Interface
REQ-001 SHALL have parameter K, default 8, number of nearest neighbours retained (K >= 2).
REQ-002 SHALL have parameter DIST_WIDTH, default 32, distance width in bits.
REQ-003 SHALL have parameter IDX_WIDTH, default 16, candidate point index width.
REQ-004 SHALL have ports, in order:
  clk  input  1  sole clock, rising edge;
  reset  input  1  asynchronous, active-high;
  query_start  input  1  pulse: clear buffer, begin new query;
  in_valid  input  1  candidate valid;
  in_ready  output  1  candidate accepted when in_valid & in_ready;
  in_distance  input  DIST_WIDTH  candidate distance;
  in_index  input  IDX_WIDTH  candidate point index;
  query_end  input  1  pulse: no more candidates, begin drain;
  running_mean  input  DIST_WIDTH  fallback threshold;
  threshold  output  DIST_WIDTH  current pruning threshold;
  count  output  $clog2(K+1)  number of valid entries;
  out_valid  output  1  result valid;
  out_ready  input  1  result consumed when out_valid & out_ready;
  out_distance  output  DIST_WIDTH  result distance;
  out_index  output  IDX_WIDTH  result index;
  out_rank  output  $clog2(K)  result rank, 0 = nearest;
  out_last  output  1  final result of the query;
  busy  output  1  state != IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, COLLECT, DRAIN.
REQ-006 IDLE->COLLECT on query_start; COLLECT->DRAIN on query_end; DRAIN->IDLE on handshake with out_last=1, or in the cycle after entry when count==0.
REQ-007 query_start in any state SHALL invalidate all entries, set count=0, enter COLLECT next cycle; it takes priority over every other input that cycle.
REQ-008 in_ready SHALL be 1 exactly in COLLECT; candidates offered in IDLE/DRAIN are neither accepted nor stored.
REQ-009 Buffer SHALL hold up to K entries sorted ascending by distance; accepted candidate inserted at the first slot whose valid distance is strictly greater, or the first invalid slot; entries at and below that slot shift down one; slot K-1 content is discarded on shift.
REQ-010 Ties SHALL keep arrival order: an equal-distance newcomer goes after existing equals.
REQ-011 When count==K and in_distance >= slot K-1 distance, the candidate SHALL be accepted and dropped (buffer unchanged).
REQ-012 Insertion SHALL complete in one cycle; buffer, count, threshold reflect the candidate in the cycle after acceptance; back-to-back candidates every cycle SHALL be supported.
REQ-013 threshold SHALL equal slot K-1 distance when count==K, else running_mean (combinational from registered buffer).
REQ-014 count SHALL saturate at K.
REQ-015 Accepted candidate in the same cycle as query_end SHALL be inserted before DRAIN begins.
REQ-016 In DRAIN, results SHALL be emitted rank 0..count-1 from registered outputs; out_valid first asserts the cycle after entering DRAIN; outputs hold stable while out_valid & !out_ready.
REQ-017 out_last SHALL be 1 only with rank count-1; DRAIN with count==0 emits nothing.
REQ-018 Distance comparison SHALL be unsigned, full DIST_WIDTH, no truncation.

Reset
REQ-019 Reset SHALL force state IDLE, all entries invalid with distance all-ones, count=0, out_valid=0, out_last=0, out_rank=0, out_distance=0, out_index=0, in_ready=0, busy=0; threshold therefore = running_mean.
REQ-020 Reset asserted mid-COLLECT or mid-DRAIN SHALL abandon the query with no further outputs.

Structure
REQ-021 knn_entry_t (valid, distance, index) and default widths SHALL live in the shared package global_defs, parameterised via DIST_WIDTH/IDX_WIDTH.
REQ-022 A sub-module topk_slot SHALL implement one buffer slot (compare newcomer, hold/shift/load); topk_stream generates K instances plus FSM and drain logic.

Verification
REQ-023 K=4: query_start, candidates 50,20,70,20(idx 9),10, query_end, out_ready=1 -> outputs 10,20,20(idx 9 second),50 ranks 0-3, out_last on rank 3, then IDLE.
REQ-024 K=4, running_mean=100: after 3 candidates threshold=100; after 4th (40,30,20,60) threshold=60; candidate 60 dropped, threshold stays 60; candidate 5 -> threshold 40.
REQ-025 Drain with out_ready toggling 1,0,0,1: each result held unchanged across stall cycles, no rank skipped or repeated.
REQ-026 query_end with count==0 -> no out_valid, busy falls one cycle after entering DRAIN.
REQ-027 query_start asserted during DRAIN after rank 1 -> out_valid deasserts next cycle, count=0, COLLECT.
REQ-028 Reset pulse mid-COLLECT with count=3 -> count=0, busy=0, threshold=running_mean immediately (asynchronous).
